// File: rtl/rsa_modexp_if.sv
// Byte-serial load bus and result/status signals of the rsa_modexp core.
// RSA_CYCLE_CNT_EN adds the rsa_cycles compute-cycle count.
interface rsa_modexp_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  rsa_load;
    logic [7:0]            rsa_din;
    logic                  rsa_busy;
    logic                  rsa_done;
    logic                  rsa_err;
    logic [DATA_WIDTH-1:0] rsa_dout;
`ifdef RSA_CYCLE_CNT_EN
    logic [15:0]           rsa_cycles;

    modport master (
        output rsa_load, rsa_din,
        input  rsa_busy, rsa_done, rsa_err, rsa_dout, rsa_cycles
    );

    modport slave (
        input  rsa_load, rsa_din,
        output rsa_busy, rsa_done, rsa_err, rsa_dout, rsa_cycles
    );
`else
    modport master (
        output rsa_load, rsa_din,
        input  rsa_busy, rsa_done, rsa_err, rsa_dout
    );

    modport slave (
        input  rsa_load, rsa_din,
        output rsa_busy, rsa_done, rsa_err, rsa_dout
    );
`endif
endinterface

// File: rtl/rsa_modexp.sv
// rsa_modexp: C = M^E mod N via a constant-time square-and-always-multiply ladder
// on a bit-serial interleaved modular multiplier. RSA_CYCLE_CNT_EN adds rsa_cycles.
module rsa_modexp #(
    parameter int   DATA_WIDTH  = 16,
    parameter logic LOAD_ACTIVE = 1'b1,
    parameter logic CLK_EDGE    = 1'b1
) (
    input logic         rsa_clk,
    input logic         rsa_rst,
    rsa_modexp_if.slave bus
);
    localparam int W      = DATA_WIDTH;
    localparam int NBYTES = 3 * (W / 8);
    localparam int CW     = $clog2(NBYTES + 1);
    localparam int SW     = $clog2(W + 1);
    localparam int IW     = $clog2(W);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, SQR, MUL, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic            clk;
    logic            load_on;
    logic            accept;
    logic            mult_last;
    logic            operand_bad;
    logic [CW-1:0]   byte_cnt;
    logic [3*W-1:0]  opnd;
    logic [W-1:0]    n_op;
    logic [W-1:0]    e_op;
    logic [W-1:0]    m_op;
    logic [W-1:0]    r_reg;
    logic [W-1:0]    mb_reg;
    logic [W-1:0]    e_sh;
    logic [W-1:0]    p_reg;
    logic [W-1:0]    p_next;
    logic [W+1:0]    p_dbl;
    logic [W+1:0]    p_add;
    logic [W+1:0]    n_ext;
    logic [SW-1:0]   step;
    logic [IW-1:0]   bit_idx;
    logic            busy;
    logic            done;
    logic            err;
    logic [W-1:0]    dout;

    // Falling-edge builds simply run the whole core on the inverted clock.
    assign clk = CLK_EDGE ? rsa_clk : ~rsa_clk;

    assign load_on     = (bus.rsa_load == LOAD_ACTIVE);
    assign n_op        = opnd[3*W-1:2*W];
    assign e_op        = opnd[2*W-1:W];
    assign m_op        = opnd[W-1:0];
    assign operand_bad = (n_op < W'(2)) || (m_op >= n_op);
    assign mult_last   = (step == SW'(W));

    always_ff @(posedge clk) begin
        if (rsa_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (load_on) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (load_on) begin
                    accept = 1'b1;
                    if (byte_cnt == CW'(NBYTES - 1)) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK:   state_next = operand_bad ? IDLE : SQR;
            SQR:     if (mult_last) state_next = MUL;
            MUL:     if (mult_last) state_next = (bit_idx == '0) ? DONE : SQR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One interleaved step: P stays below N, so W+2 bits absorb 2P + A.
    always_comb begin
        n_ext = {2'b00, n_op};
        p_dbl = {1'b0, p_reg, 1'b0};
        if (p_dbl >= n_ext) begin
            p_dbl = p_dbl - n_ext;
        end
        p_add = p_dbl;
        if (mb_reg[W-1]) begin
            p_add = p_dbl + {2'b00, r_reg};
        end
        if (p_add >= n_ext) begin
            p_next = W'(p_add - n_ext);
        end else begin
            p_next = W'(p_add);
        end
    end

    always_ff @(posedge clk) begin
        if (rsa_rst) begin
            byte_cnt <= '0;
            opnd     <= '0;
            r_reg    <= '0;
            mb_reg   <= '0;
            e_sh     <= '0;
            p_reg    <= '0;
            step     <= '0;
            bit_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            dout     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (state == IDLE) begin
                            opnd <= {{(3*W-8){1'b0}}, bus.rsa_din};
                            busy <= 1'b1;
                            err  <= 1'b0;
                            dout <= '0;
                        end else begin
                            opnd <= {opnd[3*W-9:0], bus.rsa_din};
                        end
                        byte_cnt <= (state_next == CHECK) ? '0 : byte_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (operand_bad) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        r_reg   <= W'(1);
                        e_sh    <= e_op;
                        bit_idx <= IW'(W - 1);
                        step    <= '0;
                    end
                end
                // Both phases always run a full multiply; MUL keeps its product only on E[i]=1.
                SQR, MUL: begin
                    if (step == '0) begin
                        p_reg  <= '0;
                        mb_reg <= (state == MUL) ? m_op : r_reg;
                        step   <= SW'(1);
                    end else begin
                        p_reg  <= p_next;
                        mb_reg <= {mb_reg[W-2:0], 1'b0};
                        if (mult_last) begin
                            step <= '0;
                            if (state == SQR) begin
                                r_reg <= p_next;
                            end else begin
                                if (e_sh[W-1]) begin
                                    r_reg <= p_next;
                                end
                                e_sh    <= {e_sh[W-2:0], 1'b0};
                                bit_idx <= bit_idx - IW'(1);
                            end
                        end else begin
                            step <= step + SW'(1);
                        end
                    end
                end
                DONE: begin
                    dout <= r_reg;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rsa_busy = busy;
    assign bus.rsa_done = done;
    assign bus.rsa_err  = err;
    assign bus.rsa_dout = dout;

`ifdef RSA_CYCLE_CNT_EN
    logic [15:0] cycles;

    always_ff @(posedge clk) begin
        if (rsa_rst) begin
            cycles <= '0;
        end else if (accept && state == IDLE) begin
            cycles <= '0;
        end else if ((state == CHECK || state == SQR || state == MUL || state == DONE)
                     && cycles != 16'hFFFF) begin
            cycles <= cycles + 16'd1;
        end
    end

    assign bus.rsa_cycles = cycles;
`endif
endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
Parametrised successor to the fixed 8-bit RSA core. It computes C = M^E mod N for a configurable operand width. Operands N, E and M are loaded over the existing 8-bit byte-serial load interface. The core uses a constant-time square-and-always-multiply ladder built on a bit-serial interleaved modular multiplier, and it reports result, done pulse, busy and operand error to the I/O/display layer.

Parameters:
DATA_WIDTH, 16, operand width W in bits; multiple of 8, range 8..64
LOAD_ACTIVE, 1'b1, active level of rsa_load
CLK_EDGE, 1'b1, 1 = rising-edge clocking, 0 = falling-edge clocking

Ports:
rsa_clk  input  1  core clock; the only clock
rsa_rst  input  1  synchronous reset, active-high
rsa_load  input  1  byte strobe; rsa_din is valid when rsa_load is at LOAD_ACTIVE
rsa_din  input  8  operand byte
rsa_busy  output  1  high from the first accepted byte until done or error
rsa_done  output  1  one-cycle pulse when rsa_dout is valid
rsa_err  output  1  operand error flag; stays high until the next load starts
rsa_dout  output  DATA_WIDTH  result C, held until the next load starts

Behaviour:
- Clock and reset: one clock, rsa_clk; reset is synchronous and active-high on rsa_rst. All state changes occur on the CLK_EDGE edge of rsa_clk.
- Reset: state goes to IDLE, byte counter to 0; rsa_busy=0, rsa_done=0, rsa_err=0, rsa_dout=0. Reset overrides everything, including mid-load and mid-compute; no partial result is ever emitted.
- Load sequence: B = W/8 bytes per operand, 3B bytes total, sent MSB-first in the order N, E, M.
  - A byte is accepted on any edge where rsa_load is active and the state is IDLE or LOAD.
  - Gaps between bytes are allowed; the byte counter simply holds.
  - The first accepted byte clears rsa_err, rsa_dout and the operand registers, and sets rsa_busy.
- Loads outside IDLE/LOAD: strobes in CHECK, SQR, MUL or DONE are ignored. Operands stay unchanged and no error is raised.
- State machine states: IDLE, LOAD, CHECK, SQR, MUL, DONE.
  - IDLE -> LOAD on the first accepted byte.
  - LOAD -> CHECK on the edge that accepts byte 3B.
  - CHECK (1 cycle): if N<2 or M>=N, set rsa_err=1, clear rsa_busy, go to IDLE. rsa_done is not pulsed and rsa_dout stays 0.
  - CHECK otherwise: R=1, exponent bit index i=W-1, go to SQR.
  - SQR: R = R*R mod N.
  - MUL: T = R*M mod N. At the end of MUL, R = T only if E[i]=1; otherwise R is unchanged. Then, if i=0, go to DONE; else decrement i and go to SQR.
  - Every exponent bit costs the same cycles whatever its value (constant time).
  - DONE (1 cycle): rsa_dout=R, rsa_done=1, rsa_busy=0, then go to IDLE.
- Modular multiplier (A*B mod N), exactly W+1 cycles per call:
  - Cycle 0 loads P=0.
  - Each of the next W cycles handles multiplier bit j = W-1 down to 0: P = 2P; if P>=N then P-=N; if B[j]=1 then P+=A; if P>=N then P-=N.
  - The internal accumulator is W+2 bits wide so nothing overflows. The result is always < N.
- Latency: rsa_done rises exactly 2*W*(W+1)+2 cycles after the edge that accepts the final byte. For W=16 this is 546 cycles.
- Boundary cases:
  - E=0 gives C=1.
  - M=0 with N>=2 gives C=0 (or 1 when E=0).
  - N=2^W-1 must compute correctly, with no accumulator overflow.

Optional Feature:
- Macro: RSA_CYCLE_CNT_EN.
- Compiled in: adds output port rsa_cycles (16 bits). The counter clears on the first accepted byte, increments every cycle in CHECK/SQR/MUL/DONE, saturates at 0xFFFF, and holds after DONE or error. Reset value is 0.
- Compiled out: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Encrypt (W=16): N=0x0CA1, E=0x0011, M=0x0041 -> rsa_dout=0x0AE6; done pulse exactly 546 cycles after the last byte; err=0.
- Decrypt (W=16): N=0x0CA1, E=0x0AC1, M=0x0AE6 -> rsa_dout=0x0041; busy high throughout; a load strobe mid-compute is ignored and the result is unchanged.
- Errors: M=0x0CA1 with N=0x0CA1 -> rsa_err=1 one cycle after the last byte, no done pulse, dout=0. N=0x0001 -> rsa_err=1. A following valid load clears err.
- E=0x0000, N=0x0CA1, M=0x0041 -> rsa_dout=0x0001. Bytes sent with random gaps of 0-5 cycles -> same result.
- rsa_rst asserted for 1 cycle at cycle 200 of compute -> all outputs 0 and state IDLE on the next edge; a fresh full load then completes correctly.
- W=8 build: N=0xFF, E=0x03, M=0xFE -> rsa_dout=0xFE, latency 146 cycles. With RSA_CYCLE_CNT_EN defined, rsa_cycles=146.
